// File: rtl/button_led_pkg.sv
// Shared mode encoding for the push-button LED mode controller.
package button_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    // Short-press rotation: OFF -> ON -> SLOW -> FAST -> OFF.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:  return MODE_ON;
            MODE_ON:   return MODE_SLOW;
            MODE_SLOW: return MODE_FAST;
            default:   return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a counter debouncer for the raw button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic but,
    output logic db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             but_s_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (but_s_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = but_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            but_s_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= but;
            but_s_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/button_led_ctrl.sv
// Push-button mode controller: debounce, short/long press classification,
// four-mode FSM and blink generator driving a registered LED.
module button_led_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned LONG_CYCLES     = 200000000,
    parameter int unsigned SLOW_HALF       = 50000000,
    parameter int unsigned FAST_HALF       = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       but,
    output logic       led,
    output logic [1:0] mode
);

    import button_led_pkg::*;

    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES - 1);

    localparam int unsigned PH_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] SLOW_LAST = PH_W'(SLOW_HALF - 1);
    localparam logic [PH_W-1:0] FAST_LAST = PH_W'(FAST_HALF - 1);

    logic              db;
    logic              db_prev_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_fired_q, long_fired_d;
    mode_t             mode_q, mode_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic              phase_q, phase_d;
    logic              led_q, led_d;

    logic              db_fall;
    logic              long_ev;
    logic              short_ev;
    logic [PH_W-1:0]   half_last;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .but  (but),
        .db   (db)
    );

    assign db_fall  = db_prev_q & ~db;
    assign long_ev  = db & ~long_fired_q & (hold_q == HOLD_LONG);
    assign short_ev = db_fall & ~long_fired_q;

    always_comb begin
        // Held at 0 while released, so every hold starts counting from 0.
        hold_d = '0;
        if (db) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end

        long_fired_d = long_fired_q;
        if (long_ev) begin
            long_fired_d = 1'b1;
        end else if (db_fall) begin
            long_fired_d = 1'b0;
        end

        mode_d = mode_q;
        if (long_ev) begin
            mode_d = MODE_OFF;
        end else if (short_ev) begin
            mode_d = next_mode(mode_q);
        end
    end

    always_comb begin
        ph_cnt_d  = '0;
        phase_d   = 1'b0;
        half_last = (mode_d == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
        if (mode_d == MODE_SLOW || mode_d == MODE_FAST) begin
            if (mode_d != mode_q) begin
                phase_d = 1'b1;
            end else if (ph_cnt_q == half_last) begin
                phase_d = ~phase_q;
            end else begin
                ph_cnt_d = ph_cnt_q + 1'b1;
                phase_d  = phase_q;
            end
        end

        case (mode_d)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            default:  led_d = phase_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev_q    <= 1'b0;
            hold_q       <= '0;
            long_fired_q <= 1'b0;
            mode_q       <= MODE_OFF;
            ph_cnt_q     <= '0;
            phase_q      <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            db_prev_q    <= db;
            hold_q       <= hold_d;
            long_fired_q <= long_fired_d;
            mode_q       <= mode_d;
            ph_cnt_q     <= ph_cnt_d;
            phase_q      <= phase_d;
            led_q        <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Self-checking bench for button_led_ctrl with shortened timing parameters.
module tb_button_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       but;
    logic       led;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_led_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (32),
        .SLOW_HALF      (8),
        .FAST_HALF      (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .but  (but),
        .led  (led),
        .mode (mode)
    );

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic       led;
    } exp_t;

    typedef struct {
        string      name;
        int         high;
        int         samp;
        int         len;
        logic [1:0] m;
        logic       l;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [1:0] m, input logic l);
        exp_t e;
        e.name = name;
        e.mode = m;
        e.led  = l;
        exp_q.push_back(e);
    endtask

    task automatic check_front(input bit wait_neg);
        exp_t e;
        if (wait_neg) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
            return;
        end
        e = exp_q.pop_front();
        if (mode !== e.mode) begin
            failures++;
            $display("FAIL %s mode: got %0d expected %0d (t=%0t)", e.name, mode, e.mode, $time);
        end
        checks++;
        if (led !== e.led) begin
            failures++;
            $display("FAIL %s led: got %0b expected %0b (t=%0t)", e.name, led, e.led, $time);
        end
    endtask

    // Holds but high for 'high' cycles then low, sampling once at cycle 'samp'.
    task automatic run_vec(input string name, input int high, input int samp, input int len,
                           input logic [1:0] m, input logic l);
        but = (high != 0);
        for (int t = 1; t <= len; t++) begin
            tick();
            if (t == high) but = 1'b0;
            if (t == samp) begin
                expect_state(name, m, l);
                check_front(1'b1);
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"glitch3",          3, 20, 20, 2'd1, 1'b1};
        vecs[1]  = '{"short_to_slow",   10, 17, 20, 2'd2, 1'b1};
        vecs[2]  = '{"short_to_fast",   10, 17, 20, 2'd3, 1'b1};
        vecs[3]  = '{"short_to_off",    10, 17, 20, 2'd0, 1'b0};
        vecs[4]  = '{"pulse4_to_on",     4, 20, 20, 2'd1, 1'b1};
        vecs[5]  = '{"short_to_slow2",  10, 17, 20, 2'd2, 1'b1};
        vecs[6]  = '{"long_from_slow",  60, 38, 80, 2'd0, 1'b0};
        vecs[7]  = '{"no_adv_after_long", 0, 10, 10, 2'd0, 1'b0};
        vecs[8]  = '{"short_to_on",     10, 17, 20, 2'd1, 1'b1};
        vecs[9]  = '{"long_from_on",    40, 38, 50, 2'd0, 1'b0};
        vecs[10] = '{"long_while_off",  40, 38, 50, 2'd0, 1'b0};
        vecs[11] = '{"short_after_long",10, 17, 20, 2'd1, 1'b1};
        vecs[12] = '{"hold31_short",    31, 38, 40, 2'd2, 1'b1};
        vecs[13] = '{"hold32_long",     32, 38, 50, 2'd0, 1'b0};
        vecs[14] = '{"idle_after_hold32", 0, 10, 10, 2'd0, 1'b0};

        // Reset held with the button pressed.
        rst_n = 1'b0;
        but   = 1'b1;
        repeat (10) tick();
        expect_state("reset_hold", 2'd0, 1'b0);
        check_front(1'b1);
        rst_n = 1'b1;
        but   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            expect_state("idle_after_reset", 2'd0, 1'b0);
            check_front(1'b1);
        end

        // 3-cycle pulse, then a clean press with exact event timing.
        run_vec("pulse3_ignored", 3, 20, 20, 2'd0, 1'b0);
        but = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 10) but = 1'b0;
            if (t == 16) begin
                expect_state("before_short_event", 2'd0, 1'b0);
                check_front(1'b1);
            end
            if (t == 17) begin
                expect_state("first_short_event", 2'd1, 1'b1);
                check_front(1'b1);
            end
        end

        for (int v = 0; v < 15; v++) begin
            run_vec(vecs[v].name, vecs[v].high, vecs[v].samp, vecs[v].len, vecs[v].m, vecs[v].l);
        end

        // OFF -> ON, then into SLOW and check the blink waveform.
        run_vec("to_on_for_blink", 10, 17, 20, 2'd1, 1'b1);
        but = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 10) but = 1'b0;
        end
        for (int k = 0; k < 32; k++) begin
            expect_state("slow_blink", 2'd2, ((k / 8) % 2) == 0);
            check_front(1'b1);
            tick();
        end

        // SLOW -> FAST, check the blink, then reset asynchronously mid-phase.
        but = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 10) but = 1'b0;
        end
        for (int k = 0; k <= 16; k++) begin
            expect_state("fast_blink", 2'd3, ((k / 2) % 2) == 0);
            check_front(1'b1);
            if (k < 16) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("async_reset", 2'd0, 1'b0);
        check_front(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_vec("short_after_reset", 10, 17, 20, 2'd1, 1'b1);

        // Bounce train must produce no event; the following clean press gives one.
        for (int i = 0; i < 40; i++) begin
            but = ((i / 2) % 2) == 0;
            tick();
        end
        run_vec("bounce_then_press", 10, 17, 20, 2'd2, 1'b1);
        run_vec("bounce_no_extra", 0, 20, 20, 2'd2, 1'b1);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
